mem_access_arbiter: RTL and testbench



---
 rtl/mem_access_arbiter.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_mem_access_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_arbiter.sv
// Round-robin N-port front end for one single-ported SRAM bank: splits DOUBLE
// accesses into two beats, reassembles DOUBLE reads and gates chip enable when idle.
module mem_access_arbiter #(
  parameter int N_PORTS     = 4,
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 1024,
  parameter int BANK_RD_LAT = 1,
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2,
  localparam int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_PORTS-1:0]            req_en,
  input  logic [N_PORTS-1:0]            req_write,
  input  logic [N_PORTS-1:0]            req_width,
  input  logic [N_PORTS*ADDR_W-1:0]     req_addr,
  input  logic [N_PORTS*2*DATA_W-1:0]   req_wdata,
  output logic [N_PORTS-1:0]            req_ready,
  output logic [N_PORTS-1:0]            rsp_valid,
  output logic [2*DATA_W-1:0]           rsp_data,
  output logic                          bank_en,
  output logic                          bank_chip_en,
  output logic                          bank_write,
  output logic [ADDR_W-1:0]             bank_addr,
  output logic [DATA_W-1:0]             bank_wdata,
  input  logic [DATA_W-1:0]             bank_rdata
);

  localparam int PW   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int IC_W = $clog2(IDLE_CYCLES + 2);
  localparam int WC_W = $clog2(WAKE_CYCLES + 2);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT2 = 2'd1,
    ST_SLEEP = 2'd2,
    ST_WAKE  = 2'd3
  } state_t;

  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] r;
    if (a == ADDR_W'(DEPTH - 1)) r = '0;
    else                         r = a + ADDR_W'(1);
    return r;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    logic [PW-1:0] r;
    if (int'(p) == N_PORTS - 1) r = '0;
    else                        r = p + PW'(1);
    return r;
  endfunction

  state_t               state_r, state_n;
  logic [PW-1:0]        rr_ptr_r, rr_ptr_n;
  logic [IC_W-1:0]      idle_cnt_r, idle_cnt_n;
  logic [WC_W-1:0]      wake_cnt_r, wake_cnt_n;
  logic [PW-1:0]        hold_port_r, hold_port_n;
  logic [ADDR_W-1:0]    hold_addr_r, hold_addr_n;
  logic [DATA_W-1:0]    hold_hi_r, hold_hi_n;
  logic                 hold_write_r, hold_write_n;
  logic                 bank_en_r, bank_en_n;
  logic                 bank_write_r, bank_write_n;
  logic [ADDR_W-1:0]    bank_addr_r, bank_addr_n;
  logic [DATA_W-1:0]    bank_wdata_r, bank_wdata_n;
  logic                 chip_en_r, chip_en_n;
  logic [N_PORTS-1:0]   ready_r, ready_n;
  logic [PW-1:0]        iss_port_r, iss_port_n;
  logic                 iss_dbl_r, iss_dbl_n;
  logic                 iss_last_r, iss_last_n;

  logic [N_PORTS-1:0]   eligible_s;
  logic                 grant_found_s;
  logic [PW-1:0]        grant_idx_s;
  logic [PW-1:0]        cand_s;
  logic [ADDR_W-1:0]    sel_addr_s;
  logic [2*DATA_W-1:0]  sel_wdata_s;
  logic                 inflight_s;

  logic [BANK_RD_LAT-1:0] tag_vld_r;
  logic [BANK_RD_LAT-1:0] tag_dbl_r;
  logic [BANK_RD_LAT-1:0] tag_last_r;
  logic [PW-1:0]          tag_port_r [BANK_RD_LAT];
  logic [DATA_W-1:0]      lo_word_r;
  logic [N_PORTS-1:0]     rsp_valid_r;
  logic [2*DATA_W-1:0]    rsp_data_r;

  assign req_ready    = ready_r;
  assign rsp_valid    = rsp_valid_r;
  assign rsp_data     = rsp_data_r;
  assign bank_en      = bank_en_r;
  assign bank_chip_en = chip_en_r;
  assign bank_write   = bank_write_r;
  assign bank_addr    = bank_addr_r;
  assign bank_wdata   = bank_wdata_r;

  assign inflight_s = (|tag_vld_r) | (bank_en_r & ~bank_write_r);

  // Round-robin search from rr_ptr; a port being acknowledged this cycle holds a stale req_en.
  always_comb begin
    eligible_s    = req_en & ~ready_r;
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    cand_s        = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      cand_s = PW'((int'(rr_ptr_r) + i) % N_PORTS);
      if (!grant_found_s && eligible_s[cand_s]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = cand_s;
      end else begin
        grant_found_s = grant_found_s;
      end
    end
    sel_addr_s  = req_addr[grant_idx_s*ADDR_W +: ADDR_W];
    sel_wdata_s = req_wdata[grant_idx_s*2*DATA_W +: 2*DATA_W];
  end

  // Next-state and next-output logic for the access/power FSM.
  always_comb begin
    state_n      = state_r;
    rr_ptr_n     = rr_ptr_r;
    idle_cnt_n   = idle_cnt_r;
    wake_cnt_n   = wake_cnt_r;
    hold_port_n  = hold_port_r;
    hold_addr_n  = hold_addr_r;
    hold_hi_n    = hold_hi_r;
    hold_write_n = hold_write_r;
    bank_en_n    = 1'b0;
    bank_write_n = 1'b0;
    bank_addr_n  = '0;
    bank_wdata_n = '0;
    chip_en_n    = 1'b1;
    ready_n      = '0;
    iss_port_n   = '0;
    iss_dbl_n    = 1'b0;
    iss_last_n   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (grant_found_s) begin
          bank_en_n    = 1'b1;
          bank_write_n = req_write[grant_idx_s];
          bank_addr_n  = sel_addr_s;
          bank_wdata_n = sel_wdata_s[DATA_W-1:0];
          iss_port_n   = grant_idx_s;
          iss_dbl_n    = req_width[grant_idx_s];
          iss_last_n   = ~req_width[grant_idx_s];
          rr_ptr_n     = ptr_inc(grant_idx_s);
          idle_cnt_n   = '0;
          if (req_width[grant_idx_s]) begin
            state_n      = ST_BEAT2;
            hold_port_n  = grant_idx_s;
            hold_addr_n  = addr_inc(sel_addr_s);
            hold_hi_n    = sel_wdata_s[2*DATA_W-1:DATA_W];
            hold_write_n = req_write[grant_idx_s];
          end else begin
            ready_n[grant_idx_s] = 1'b1;
          end
        end else if (inflight_s || IDLE_CYCLES == 0) begin
          idle_cnt_n = '0;
        end else if (idle_cnt_r >= IC_W'(IDLE_CYCLES)) begin
          state_n    = ST_SLEEP;
          chip_en_n  = 1'b0;
          idle_cnt_n = '0;
        end else begin
          idle_cnt_n = idle_cnt_r + IC_W'(1);
        end
      end
      ST_BEAT2: begin
        bank_en_n            = 1'b1;
        bank_write_n         = hold_write_r;
        bank_addr_n          = hold_addr_r;
        bank_wdata_n         = hold_hi_r;
        ready_n[hold_port_r] = 1'b1;
        iss_port_n           = hold_port_r;
        iss_dbl_n            = 1'b1;
        iss_last_n           = 1'b1;
        state_n              = ST_IDLE;
      end
      ST_SLEEP: begin
        wake_cnt_n = '0;
        if (|req_en) begin
          state_n = (WAKE_CYCLES <= 1) ? ST_IDLE : ST_WAKE;
        end else begin
          chip_en_n = 1'b0;
        end
      end
      ST_WAKE: begin
        // The SLEEP->WAKE edge already raised chip_en, so WAKE lasts WAKE_CYCLES-1 cycles.
        if (int'(wake_cnt_r) >= WAKE_CYCLES - 2) begin
          state_n    = ST_IDLE;
          wake_cnt_n = '0;
        end else begin
          wake_cnt_n = wake_cnt_r + WC_W'(1);
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // FSM state, hold registers and registered bank/ready outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      rr_ptr_r     <= '0;
      idle_cnt_r   <= '0;
      wake_cnt_r   <= '0;
      hold_port_r  <= '0;
      hold_addr_r  <= '0;
      hold_hi_r    <= '0;
      hold_write_r <= 1'b0;
      bank_en_r    <= 1'b0;
      bank_write_r <= 1'b0;
      bank_addr_r  <= '0;
      bank_wdata_r <= '0;
      chip_en_r    <= 1'b1;
      ready_r      <= '0;
      iss_port_r   <= '0;
      iss_dbl_r    <= 1'b0;
      iss_last_r   <= 1'b0;
    end else begin
      state_r      <= state_n;
      rr_ptr_r     <= rr_ptr_n;
      idle_cnt_r   <= idle_cnt_n;
      wake_cnt_r   <= wake_cnt_n;
      hold_port_r  <= hold_port_n;
      hold_addr_r  <= hold_addr_n;
      hold_hi_r    <= hold_hi_n;
      hold_write_r <= hold_write_n;
      bank_en_r    <= bank_en_n;
      bank_write_r <= bank_write_n;
      bank_addr_r  <= bank_addr_n;
      bank_wdata_r <= bank_wdata_n;
      chip_en_r    <= chip_en_n;
      ready_r      <= ready_n;
      iss_port_r   <= iss_port_n;
      iss_dbl_r    <= iss_dbl_n;
      iss_last_r   <= iss_last_n;
    end
  end

  // Read tag pipe: the last stage lines up with bank_rdata of the tagged beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld_r  <= '0;
      tag_dbl_r  <= '0;
      tag_last_r <= '0;
      for (int k = 0; k < BANK_RD_LAT; k++) tag_port_r[k] <= '0;
    end else begin
      for (int k = BANK_RD_LAT - 1; k > 0; k--) begin
        tag_vld_r[k]  <= tag_vld_r[k-1];
        tag_dbl_r[k]  <= tag_dbl_r[k-1];
        tag_last_r[k] <= tag_last_r[k-1];
        tag_port_r[k] <= tag_port_r[k-1];
      end
      tag_vld_r[0]  <= bank_en_r & ~bank_write_r;
      tag_dbl_r[0]  <= iss_dbl_r;
      tag_last_r[0] <= iss_last_r;
      tag_port_r[0] <= iss_port_r;
    end
  end

  // Low-word capture and registered read response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_word_r   <= '0;
      rsp_valid_r <= '0;
      rsp_data_r  <= '0;
    end else begin
      rsp_valid_r <= '0;
      if (tag_vld_r[BANK_RD_LAT-1] && tag_last_r[BANK_RD_LAT-1]) begin
        rsp_valid_r[tag_port_r[BANK_RD_LAT-1]] <= 1'b1;
        rsp_data_r <= tag_dbl_r[BANK_RD_LAT-1] ? {bank_rdata, lo_word_r}
                                               : {{DATA_W{1'b0}}, bank_rdata};
      end else if (tag_vld_r[BANK_RD_LAT-1]) begin
        lo_word_r <= bank_rdata;
      end else begin
        lo_word_r <= lo_word_r;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed self-checking bench for mem_access_arbiter (4 ports, 16-bit words,
// 1-cycle bank, short idle/wake periods) with a read-only bank model.
module tb_mem_access_arbiter;

  localparam int NP = 4;
  localparam int DW = 16;
  localparam int AW = 10;

  logic            clk;
  logic            rst_n;
  logic [NP-1:0]   req_en;
  logic [NP-1:0]   req_write;
  logic [NP-1:0]   req_width;
  logic [NP*AW-1:0]   req_addr;
  logic [NP*2*DW-1:0] req_wdata;
  logic [NP-1:0]   req_ready;
  logic [NP-1:0]   rsp_valid;
  logic [2*DW-1:0] rsp_data;
  logic            bank_en;
  logic            bank_chip_en;
  logic            bank_write;
  logic [AW-1:0]   bank_addr;
  logic [DW-1:0]   bank_wdata;
  logic [DW-1:0]   bank_rdata;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  logic [NP-1:0] seen;

  mem_access_arbiter #(
    .N_PORTS(4), .DATA_W(16), .DEPTH(1024), .BANK_RD_LAT(1),
    .IDLE_CYCLES(4), .WAKE_CYCLES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_en(req_en), .req_write(req_write), .req_width(req_width),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .bank_en(bank_en), .bank_chip_en(bank_chip_en), .bank_write(bank_write),
    .bank_addr(bank_addr), .bank_wdata(bank_wdata), .bank_rdata(bank_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    logic [DW-1:0] w;
    case (a)
      10'd5:  w = 16'h1234;
      10'd8:  w = 16'h1111;
      10'd9:  w = 16'h2222;
      10'd16, 10'd17, 10'd18, 10'd19: w = 16'hA000 | {12'd0, a[3:0]};
      default: w = {6'd0, a} ^ 16'h5A5A;
    endcase
    return w;
  endfunction

  // Bank model with one cycle of read latency; contents are a fixed pattern.
  always @(posedge clk) begin
    if (bank_en && bank_chip_en && !bank_write) bank_rdata <= init_word(bank_addr);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_req(input int p, input logic wr, input logic wd,
                         input logic [AW-1:0] a, input logic [2*DW-1:0] d);
    req_en[p]              = 1'b1;
    req_write[p]           = wr;
    req_width[p]           = wd;
    req_addr[p*AW +: AW]   = a;
    req_wdata[p*2*DW +: 2*DW] = d;
  endtask

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, "_bank_en"},   64'(bank_en),      64'd0);
    chk({pfx, "_chip_en"},   64'(bank_chip_en), 64'd1);
    chk({pfx, "_bank_addr"}, 64'(bank_addr),    64'd0);
    chk({pfx, "_req_ready"}, 64'(req_ready),    64'd0);
    chk({pfx, "_rsp_valid"}, 64'(rsp_valid),    64'd0);
    chk({pfx, "_rsp_data"},  64'(rsp_data),     64'd0);
  endtask

  // Reset, leaving the bench at mid-cycle 0 with reset released.
  task automatic do_reset();
    req_en = '0;
    rst_n  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    req_en = '0; req_write = '0; req_width = '0; req_addr = '0; req_wdata = '0;

    // Reset values
    rst_n = 1'b0;
    tick();
    check_reset_outputs("rst");
    do_reset();

    // Single read, port 2, addr 5
    set_req(2, 1'b0, 1'b0, 10'd5, 32'd0);
    tick();
    chk("sr_bank_en",   64'(bank_en),    64'd1);
    chk("sr_bank_wr",   64'(bank_write), 64'd0);
    chk("sr_bank_addr", 64'(bank_addr),  64'd5);
    chk("sr_ready",     64'(req_ready),  64'b0100);
    req_en = '0;
    tick();
    chk("sr_rsp_early", 64'(rsp_valid),  64'd0);
    tick();
    chk("sr_rsp_valid", 64'(rsp_valid),  64'b0100);
    chk("sr_rsp_data",  64'(rsp_data),   64'h0000_1234);

    // Double write at the top address wraps to 0
    do_reset();
    set_req(1, 1'b1, 1'b1, 10'd1023, 32'hBEEF_CAFE);
    tick();
    chk("dw_b1_en",    64'(bank_en),    64'd1);
    chk("dw_b1_wr",    64'(bank_write), 64'd1);
    chk("dw_b1_addr",  64'(bank_addr),  64'd1023);
    chk("dw_b1_wdata", 64'(bank_wdata), 64'hCAFE);
    chk("dw_b1_ready", 64'(req_ready),  64'd0);
    tick();
    chk("dw_b2_en",    64'(bank_en),    64'd1);
    chk("dw_b2_wr",    64'(bank_write), 64'd1);
    chk("dw_b2_addr",  64'(bank_addr),  64'd0);
    chk("dw_b2_wdata", 64'(bank_wdata), 64'hBEEF);
    chk("dw_b2_ready", 64'(req_ready),  64'b0010);
    req_en = '0;
    seen = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      seen = seen | rsp_valid;
    end
    chk("dw_no_rsp", 64'(seen), 64'd0);

    // All four ports stream SINGLE reads
    do_reset();
    for (int p = 0; p < NP; p++) set_req(p, 1'b0, 1'b0, AW'(16 + p), 32'd0);
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk($sformatf("rr_ready_c%0d", k), 64'(req_ready), 64'(4'b0001 << ((k - 1) % 4)));
      chk($sformatf("rr_en_c%0d", k),    64'(bank_en),   64'd1);
      chk($sformatf("rr_addr_c%0d", k),  64'(bank_addr), 64'(16 + (k - 1) % 4));
      if (k >= 3) begin
        chk($sformatf("rr_rspv_c%0d", k), 64'(rsp_valid), 64'(4'b0001 << ((k - 3) % 4)));
        chk($sformatf("rr_rspd_c%0d", k), 64'(rsp_data),  64'(32'h0000_A000 + (k - 3) % 4));
      end
    end
    req_en = '0;

    // Double read, port 3, addr 8
    do_reset();
    set_req(3, 1'b0, 1'b1, 10'd8, 32'd0);
    tick();
    chk("dr_b1_addr",  64'(bank_addr), 64'd8);
    chk("dr_b1_ready", 64'(req_ready), 64'd0);
    tick();
    chk("dr_b2_addr",  64'(bank_addr), 64'd9);
    chk("dr_b2_ready", 64'(req_ready), 64'b1000);
    req_en = '0;
    tick();
    chk("dr_rsp_early", 64'(rsp_valid), 64'd0);
    tick();
    chk("dr_rsp_valid", 64'(rsp_valid), 64'b1000);
    chk("dr_rsp_data",  64'(rsp_data),  64'h2222_1111);

    // Sleep after 4 idle cycles, then wake on a request
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("sl_chip_c%0d", k), 64'(bank_chip_en), (k < 5) ? 64'd1 : 64'd0);
    end
    set_req(0, 1'b0, 1'b0, 10'd5, 32'd0);
    tick();
    chk("wk_chip_c7", 64'(bank_chip_en), 64'd1);
    chk("wk_en_c7",   64'(bank_en),      64'd0);
    tick();
    chk("wk_en_c8",   64'(bank_en),      64'd0);
    tick();
    chk("wk_en_c9",    64'(bank_en),   64'd1);
    chk("wk_ready_c9", 64'(req_ready), 64'b0001);
    req_en = '0;
    tick();
    tick();
    chk("wk_rsp_valid", 64'(rsp_valid), 64'b0001);
    chk("wk_rsp_data",  64'(rsp_data),  64'h0000_1234);

    // Reset between the two beats of a DOUBLE read
    do_reset();
    set_req(1, 1'b0, 1'b1, 10'd8, 32'd0);
    tick();
    chk("mr_b1_en", 64'(bank_en), 64'd1);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("mr_async");
    req_en = '0;
    tick();
    rst_n = 1'b1;
    seen = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      seen = seen | rsp_valid;
    end
    chk("mr_no_rsp", 64'(seen), 64'd0);
    set_req(0, 1'b0, 1'b0, 10'd9, 32'd0);
    tick();
    chk("mr_next_en",    64'(bank_en),   64'd1);
    chk("mr_next_ready", 64'(req_ready), 64'b0001);
    req_en = '0;
    tick();
    tick();
    chk("mr_next_rspv", 64'(rsp_valid), 64'b0001);
    chk("mr_next_rspd", 64'(rsp_data),  64'h0000_2222);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
